// File: rtl/senales_pkg.sv
// rtl/senales_pkg.sv - shared types and constants for the printer/scanner control core
package senales_pkg;

  // Full cartridge level in pages and the width of each level counter
  localparam int INK_MAX_DEF = 7;
  localparam int INK_W       = 3;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_IDLE,
    ST_SCAN,
    ST_PRINT,
    ST_NO_INK,
    ST_DONE
  } state_t;

  // Symbol codes fed to the 7-segment decoder; 0..4 are the digits themselves
  typedef enum logic [3:0] {
    SYM_0     = 4'd0,
    SYM_1     = 4'd1,
    SYM_2     = 4'd2,
    SYM_3     = 4'd3,
    SYM_4     = 4'd4,
    SYM_S     = 4'd5,
    SYM_P     = 4'd6,
    SYM_E     = 4'd7,
    SYM_C     = 4'd8,
    SYM_B     = 4'd9,
    SYM_D     = 4'd10,
    SYM_DASH  = 4'd11,
    SYM_BLANK = 4'd12
  } sym_t;

  // Segment patterns, active-high, segment a in bit 0 through segment g in bit 6
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_S     = 7'b1101101;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Remaining-page count (0..4) shown as its own digit
  function automatic sym_t digit_sym(input logic [2:0] n);
    return sym_t'({1'b0, n});
  endfunction

endpackage

// File: rtl/senales_if.sv
// rtl/senales_if.sv - front-panel inputs and mechanism/display outputs of the control core
interface senales_if;

  logic       prendido;
  logic       color;
  logic       escanear;
  logic       imprimir;
  logic [1:0] ajustes_escaner;
  logic       rellenar_color;
  logic       rellenar_negro;
  logic [1:0] paginas;

  logic       esc_escaner;
  logic       fin_color;
  logic       fin_negro;
  logic [6:0] display1;
  logic [6:0] display2;

  modport master (
    output prendido, color, escanear, imprimir, ajustes_escaner,
           rellenar_color, rellenar_negro, paginas,
    input  esc_escaner, fin_color, fin_negro, display1, display2
  );

  modport slave (
    input  prendido, color, escanear, imprimir, ajustes_escaner,
           rellenar_color, rellenar_negro, paginas,
    output esc_escaner, fin_color, fin_negro, display1, display2
  );

endinterface

// File: rtl/senales_seg7.sv
// rtl/senales_seg7.sv - symbol code to 7-segment pattern decoder
module senales_seg7
  import senales_pkg::*;
(
  input  sym_t       i_sym,
  output logic [6:0] o_seg
);

  // Pure lookup; unknown codes show nothing
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_sym)
      SYM_0:     o_seg = SEG_0;
      SYM_1:     o_seg = SEG_1;
      SYM_2:     o_seg = SEG_2;
      SYM_3:     o_seg = SEG_3;
      SYM_4:     o_seg = SEG_4;
      SYM_S:     o_seg = SEG_S;
      SYM_P:     o_seg = SEG_P;
      SYM_E:     o_seg = SEG_E;
      SYM_C:     o_seg = SEG_C;
      SYM_B:     o_seg = SEG_B;
      SYM_D:     o_seg = SEG_D;
      SYM_DASH:  o_seg = SEG_DASH;
      default:   o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/senales.sv
// rtl/senales.sv - printer/scanner job sequencer with ink tracking and two-digit display
module senales
  import senales_pkg::*;
#(
  parameter int INK_MAX     = INK_MAX_DEF,
  parameter int PAGE_CYCLES = 4,
  parameter int SCAN_BASE   = 2
) (
  input  logic     clk,
  input  logic     reset,
  senales_if.slave bus
);

  localparam logic [INK_W-1:0] INK_FULL  = INK_W'(INK_MAX);
  localparam logic [3:0]       PAGE_LAST = 4'(PAGE_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_pages, w_pages_nxt;
  logic [1:0]       r_q, w_q_nxt;
  logic             r_color, w_color_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [INK_W-1:0] r_ink_c, r_ink_b, w_ink_c_nxt, w_ink_b_nxt;
  logic             w_dec_c, w_dec_b;

  logic [3:0]       w_scan_last;
  logic [INK_W-1:0] w_sel_ink;
  logic             w_refill_sel;

  sym_t             w_sym1, w_sym2;
  logic [6:0]       w_seg1, w_seg2;

  logic             r_esc;
  logic             r_fin_c, r_fin_b;
  logic [6:0]       r_display1, r_display2;

  // Last cycle index of a scanned page: SCAN_BASE*(q+1) cycles per page
  assign w_scan_last  = 4'(SCAN_BASE * (int'(r_q) + 1) - 1);
  assign w_sel_ink    = r_color ? r_ink_c : r_ink_b;
  assign w_refill_sel = r_color ? bus.rellenar_color : bus.rellenar_negro;

  // Job sequencing: next state, latched job parameters, cycle counter and ink-use strobes
  always_comb begin
    w_state_nxt = r_state;
    w_pages_nxt = r_pages;
    w_q_nxt     = r_q;
    w_color_nxt = r_color;
    w_cnt_nxt   = r_cnt;
    w_dec_c     = 1'b0;
    w_dec_b     = 1'b0;
    if (!bus.prendido) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: w_state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (bus.imprimir) begin
            w_pages_nxt = {1'b0, bus.paginas} + 3'd1;
            w_color_nxt = bus.color;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_PRINT;
          end else if (bus.escanear) begin
            w_pages_nxt = {1'b0, bus.paginas} + 3'd1;
            w_q_nxt     = bus.ajustes_escaner;
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_cnt == w_scan_last) begin
            w_cnt_nxt   = 4'd0;
            w_pages_nxt = r_pages - 3'd1;
            if (r_pages == 3'd1) w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        ST_PRINT: begin
          // Ink is checked only when a page is about to start, never mid-page
          if (r_cnt == 4'd0 && w_sel_ink == '0) begin
            w_state_nxt = ST_NO_INK;
          end else if (r_cnt == PAGE_LAST) begin
            w_cnt_nxt   = 4'd0;
            w_dec_c     = r_color;
            w_dec_b     = !r_color;
            w_pages_nxt = r_pages - 3'd1;
            if (r_pages == 3'd1) w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
        ST_NO_INK: begin
          if (w_refill_sel) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = ST_PRINT;
          end
        end
        ST_DONE: begin
          if (!bus.escanear && !bus.imprimir) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Ink levels: a refill wins over a decrement landing in the same cycle
  always_comb begin
    w_ink_c_nxt = r_ink_c;
    w_ink_b_nxt = r_ink_b;
    if (bus.rellenar_color)  w_ink_c_nxt = INK_FULL;
    else if (w_dec_c)        w_ink_c_nxt = r_ink_c - 1'b1;
    if (bus.rellenar_negro)  w_ink_b_nxt = INK_FULL;
    else if (w_dec_b)        w_ink_b_nxt = r_ink_b - 1'b1;
  end

  // Display symbols follow the upcoming state so the digits change together with it
  always_comb begin
    w_sym1 = SYM_BLANK;
    w_sym2 = SYM_BLANK;
    case (w_state_nxt)
      ST_IDLE: w_sym1 = SYM_DASH;
      ST_SCAN: begin
        w_sym1 = SYM_S;
        w_sym2 = digit_sym(w_pages_nxt);
      end
      ST_PRINT: begin
        w_sym1 = SYM_P;
        w_sym2 = digit_sym(w_pages_nxt);
      end
      ST_NO_INK: begin
        w_sym1 = SYM_E;
        w_sym2 = w_color_nxt ? SYM_C : SYM_B;
      end
      ST_DONE: begin
        w_sym1 = SYM_D;
        w_sym2 = SYM_0;
      end
      default: begin
        w_sym1 = SYM_BLANK;
        w_sym2 = SYM_BLANK;
      end
    endcase
  end

  senales_seg7 u_seg1 (
    .i_sym (w_sym1),
    .o_seg (w_seg1)
  );

  senales_seg7 u_seg2 (
    .i_sym (w_sym2),
    .o_seg (w_seg2)
  );

  // State register and job datapath; reset aborts any job and refills both cartridges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pages <= 3'd0;
      r_q     <= 2'd0;
      r_color <= 1'b0;
      r_cnt   <= 4'd0;
      r_ink_c <= INK_FULL;
      r_ink_b <= INK_FULL;
    end else begin
      r_state <= w_state_nxt;
      r_pages <= w_pages_nxt;
      r_q     <= w_q_nxt;
      r_color <= w_color_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ink_c <= w_ink_c_nxt;
      r_ink_b <= w_ink_b_nxt;
    end
  end

  // Output registers; the empty flags trail the level registers by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_esc      <= 1'b0;
      r_fin_c    <= 1'b0;
      r_fin_b    <= 1'b0;
      r_display1 <= SEG_DASH;
      r_display2 <= SEG_BLANK;
    end else begin
      r_esc      <= (w_state_nxt == ST_SCAN);
      r_fin_c    <= (r_ink_c == '0);
      r_fin_b    <= (r_ink_b == '0);
      r_display1 <= w_seg1;
      r_display2 <= w_seg2;
    end
  end

  assign bus.esc_escaner = r_esc;
  assign bus.fin_color   = r_fin_c;
  assign bus.fin_negro   = r_fin_b;
  assign bus.display1    = r_display1;
  assign bus.display2    = r_display2;

endmodule

// File: tb/tb_senales.sv
// tb/tb_senales.sv - self-checking bench for the printer/scanner control core
module tb_senales;

  logic clk = 1'b0;
  logic reset = 1'b1;

  senales_if bus ();

  senales dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One clock of stimulus and the outputs expected right after that clock edge
  typedef struct {
    logic       rst, pw, er, pr, col, rc, rb;
    logic [1:0] aj, pg;
    logic       e_esc, e_fc, e_fb;
    logic [6:0] e_d1, e_d2;
  } vec_t;

  vec_t steps[$];
  int   m_c = 7;
  int   m_b = 7;
  int   n_chk = 0;
  int   n_err = 0;

  // Segment pattern from the a..g reading order into a-in-bit-0 form
  function automatic logic [6:0] seg(input byte c);
    logic [6:0] s;
    logic [6:0] r;
    case (c)
      "0": s = 7'b1111110;
      "1": s = 7'b0110000;
      "2": s = 7'b1101101;
      "3": s = 7'b1111001;
      "4": s = 7'b0110011;
      "S": s = 7'b1011011;
      "P": s = 7'b1100111;
      "E": s = 7'b1001111;
      "C": s = 7'b1001110;
      "b": s = 7'b0011111;
      "d": s = 7'b0111101;
      "-": s = 7'b0000001;
      default: s = 7'b0000000;
    endcase
    for (int i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  function automatic logic [6:0] dig(input int n);
    return seg(byte'(48 + n));
  endfunction

  // Reference model: ink levels advance with the scheduled stimulus; empty flags lag a cycle
  function automatic void add(input logic rst, pw, er, pr, col, input int aj, pg,
                              input logic rc, rb, e_esc, input logic [6:0] d1, d2,
                              input logic dc, db);
    vec_t v;
    v.rst = rst; v.pw = pw; v.er = er; v.pr = pr; v.col = col;
    v.aj = 2'(aj); v.pg = 2'(pg); v.rc = rc; v.rb = rb;
    v.e_esc = e_esc; v.e_d1 = d1; v.e_d2 = d2;
    if (rst) begin
      v.e_fc = 1'b0; v.e_fb = 1'b0;
      m_c = 7; m_b = 7;
    end else begin
      v.e_fc = (m_c == 0);
      v.e_fb = (m_b == 0);
      if (rc) m_c = 7; else if (dc) m_c = m_c - 1;
      if (rb) m_b = 7; else if (db) m_b = m_b - 1;
    end
    steps.push_back(v);
  endfunction

  function automatic int rn2();
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic rn1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void idle(input logic rc, rb);
    add(0, 1, 0, 0, rn1(), rn2(), rn2(), rc, rb, 0, seg("-"), seg(" "), 0, 0);
  endfunction

  // Scan job: pages*SCAN_BASE*(q+1) cycles of 'S', remaining page count on the right digit
  function automatic void scan_job(input int pg, q, input logic hold);
    int n = pg + 1;
    int t = 2 * (q + 1);
    add(0, 1, 1, 0, rn1(), q, pg, 0, 0, 1, seg("S"), dig(n), 0, 0);
    for (int j = 1; j < n * t; j++)
      add(0, 1, hold, 0, rn1(), rn2(), rn2(), 0, 0, 1, seg("S"), dig(n - j / t), 0, 0);
    add(0, 1, hold, 0, rn1(), rn2(), rn2(), 0, 0, 0, seg("d"), seg("0"), 0, 0);
    if (hold) add(0, 1, 1, 0, rn1(), rn2(), rn2(), 0, 0, 0, seg("d"), seg("0"), 0, 0);
    idle(0, 0);
  endfunction

  // Print job: four cycles per page, one ink unit per page, stall on an empty cartridge
  function automatic void print_job(input int pg, input logic col, input int wt, input logic both);
    int n = pg + 1;
    add(0, 1, both, 1, col, rn2(), pg, 0, 0, 0, seg("P"), dig(n), 0, 0);
    for (int r = n; r >= 1; r--) begin
      if ((col ? m_c : m_b) == 0) begin
        for (int w = 0; w <= wt; w++)
          add(0, 1, 0, 0, rn1(), rn2(), rn2(), 0, 0, 0, seg("E"), col ? seg("C") : seg("b"), 0, 0);
        add(0, 1, 0, 0, rn1(), rn2(), rn2(), col, !col, 0, seg("P"), dig(r), 0, 0);
      end
      for (int k = 0; k < 3; k++)
        add(0, 1, 0, 0, rn1(), rn2(), rn2(), 0, 0, 0, seg("P"), dig(r), 0, 0);
      if (r > 1) add(0, 1, 0, 0, rn1(), rn2(), rn2(), 0, 0, 0, seg("P"), dig(r - 1), col, !col);
      else       add(0, 1, 0, 0, rn1(), rn2(), rn2(), 0, 0, 0, seg("d"), seg("0"), col, !col);
    end
    idle(0, 0);
  endfunction

  task automatic chk(input string name, input int idx, input logic [6:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    bus.prendido = 1'b1; bus.color = 1'b0; bus.escanear = 1'b0; bus.imprimir = 1'b0;
    bus.ajustes_escaner = 2'd0; bus.rellenar_color = 1'b0; bus.rellenar_negro = 1'b0;
    bus.paginas = 2'd0;

    // Reset values, then idle
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, seg("-"), seg(" "), 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, seg("-"), seg(" "), 0, 0);
    idle(0, 0);
    idle(0, 0);

    // Scans at max and low quality; the low one holds the request through DONE
    scan_job(3, 3, 0);
    scan_job(0, 1, 1);

    // Colour prints: 7 -> 5 -> 1, then exhaustion with a stall and refill, ending at 4
    print_job(1, 1, 0, 0);
    print_job(3, 1, 0, 0);
    print_job(3, 1, 3, 0);

    // Both requests together: print wins, scanner stays off
    print_job(0, 0, 0, 1);

    // Refill on the same cycle as a black page completes keeps the cartridge full
    add(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, seg("P"), dig(1), 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 1, 3, 3, 0, 0, 0, seg("P"), dig(1), 0, 0);
    add(0, 1, 0, 0, 1, 3, 3, 0, 1, 0, seg("d"), seg("0"), 0, 1);
    idle(0, 0);
    print_job(3, 0, 0, 0);
    print_job(2, 0, 0, 0);
    print_job(0, 0, 2, 0);

    // Power removed mid-scan, then restored
    add(0, 1, 1, 0, 0, 0, 1, 0, 0, 1, seg("S"), dig(2), 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, seg("S"), dig(2), 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, seg(" "), seg(" "), 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, seg(" "), seg(" "), 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, seg("-"), seg(" "), 0, 0);

    // Reset in the middle of a colour print
    add(0, 1, 0, 1, 1, 0, 3, 0, 0, 0, seg("P"), dig(4), 0, 0);
    for (int k = 0; k < 3; k++) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, seg("P"), dig(4), 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, seg("P"), dig(3), 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, seg("P"), dig(3), 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, seg("-"), seg(" "), 0, 0);
    idle(0, 0);

    // Random jobs with occasional refills between them
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(0, 2) == 0) scan_job(rn2(), rn2(), rn1());
      else print_job(rn2(), rn1(), rn2(), rn1());
      idle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < steps.size(); i++) begin
      vec_t v;
      v = steps[i];
      reset = v.rst;
      bus.prendido = v.pw; bus.escanear = v.er; bus.imprimir = v.pr; bus.color = v.col;
      bus.ajustes_escaner = v.aj; bus.paginas = v.pg;
      bus.rellenar_color = v.rc; bus.rellenar_negro = v.rb;
      @(posedge clk);
      #1;
      chk("esc_escaner", i, {6'd0, bus.esc_escaner}, {6'd0, v.e_esc});
      chk("fin_color",   i, {6'd0, bus.fin_color},   {6'd0, v.e_fc});
      chk("fin_negro",   i, {6'd0, bus.fin_negro},   {6'd0, v.e_fb});
      chk("display1",    i, bus.display1, v.e_d1);
      chk("display2",    i, bus.display2, v.e_d2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
